pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter ADDRESSWIDTH, default 4, register address width.
REQ-002 Parameter NUMSRC, default 2, source operands per instruction (1..4).
REQ-003 Parameter MCLATENCY, default 4, execute-stage cycles of a multi-cycle op (1..16).
REQ-004 Parameter CNTWIDTH, default 16, performance counter width.
REQ-005 Port clock  in  1  sole clock, rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset.
REQ-007 Port srcAddrD, srcValidD  in  NUMSRC*ADDRESSWIDTH, NUMSRC  Decode-stage sources and valids.
REQ-008 Port srcAddrE, srcValidE  in  NUMSRC*ADDRESSWIDTH, NUMSRC  Execute-stage sources and valids.
REQ-009 Port destAddrE, writeEnableE, isLoadE, isMultiE  in  ADDRESSWIDTH,1,1,1  Execute-stage destination, writeback enable, load flag, multi-cycle flag.
REQ-010 Port destAddrM, writeEnableM  in  ADDRESSWIDTH,1  Memory-stage destination.
REQ-011 Port destAddrWB, writeEnableWB  in  ADDRESSWIDTH,1  Writeback-stage destination.
REQ-012 Port takeBranchE  in  1  branch resolved taken in Execute.
REQ-013 Port forwardSelE  out  2*NUMSRC  per source: 00 register file, 01 WB, 10 M.
REQ-014 Port stallF, stallD, stallE, flushD, flushE, bubbleM  out  1 each  pipeline controls.
REQ-015 Port stallCycles, flushCount  out  CNTWIDTH each  performance counters.

Function
REQ-016 forwardSelE[i] SHALL be 10 when srcValidE[i], writeEnableM and srcAddrE[i]==destAddrM; else 01 on the same match against WB; else 00 (M beats WB); combinational.
REQ-017 Load-use hazard SHALL be: state RUN, isLoadE, writeEnableE, and any valid srcAddrD[i]==destAddrE.
REQ-018 On load-use hazard stallF=stallD=flushE=1 for that cycle only.
REQ-019 takeBranchE SHALL assert flushD=flushE=1 that cycle and suppress load-use stalls and multi-cycle entry.
REQ-020 FSM states RUN, MCBUSY, MCDONE; held in a registered state plus a down-counter.
REQ-021 RUN->MCBUSY when isMultiE, no takeBranchE, MCLATENCY>=3; counter loads MCLATENCY-2.
REQ-022 RUN->MCDONE when isMultiE, no takeBranchE, MCLATENCY==2.
REQ-023 MCLATENCY==1: isMultiE ignored, no stall ever.
REQ-024 MCBUSY: counter decrements each cycle; at counter==1 next state MCDONE.
REQ-025 MCDONE->RUN unconditionally; isMultiE ignored in MCBUSY and MCDONE.
REQ-026 stallF=stallD=stallE=bubbleM=1 in the RUN entry cycle and every MCBUSY cycle (MCLATENCY-1 cycles total); all zero in MCDONE, so the op leaves E on cycle MCLATENCY.
REQ-027 During MCBUSY/MCDONE, load-use stall and flushE are not raised; forwarding stays active.
REQ-028 stallCycles SHALL increment on each cycle stallF=1, saturating at all-ones.
REQ-029 flushCount SHALL increment on each cycle takeBranchE=1, saturating at all-ones.

Reset
REQ-030 reset==0 at a rising edge SHALL force state RUN, counter 0, stallCycles 0, flushCount 0.
REQ-031 Reset mid-MCBUSY SHALL abandon the op: next cycle RUN with no stall unless new inputs require one.
REQ-032 Combinational outputs while reset is low SHALL follow REQ-016..019 with state RUN.

Structure
REQ-033 Shared package pipeline_pkg SHALL hold the FSM state enum and forward-select encodings (FWD_REG, FWD_WB, FWD_M).
REQ-034 One sub-module fwd_select SHALL compute one operand's forward select; instantiate NUMSRC times via generate.

Verification
REQ-035 WB writes r3, M writes r3, srcAddrE[0]=3 valid -> forwardSelE[0]=10; M disabled -> 01; both disabled -> 00.
REQ-036 Load to r5 in E, srcAddrD[1]=5 valid -> one cycle stallF=stallD=flushE=1, stallCycles 0->1.
REQ-037 MCLATENCY=4, isMultiE held high -> stalls/bubbleM high exactly 3 cycles, low on cycle 4, then RUN; stallCycles=3.
REQ-038 takeBranchE with isMultiE and load-use hazard same cycle -> flushD=flushE=1, no stalls, state stays RUN, flushCount+1.
REQ-039 Reset asserted in second MCBUSY cycle -> next cycle RUN, counters 0, stalls low.
REQ-040 Force 2^CNTWIDTH+5 stall cycles (CNTWIDTH=4) -> stallCycles holds 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM state and the
// per-operand forward-select encodings.
package pipeline_pkg;

  localparam int unsigned FWD_SEL_W = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MCBUSY = 2'd1,
    ST_MCDONE = 2'd2
  } pipe_state_t;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bus: decode/execute/memory/writeback hazard inputs and
// the forward/stall/flush controls plus performance counters.
// master: pipeline datapath side (drives stage info, receives controls)
// slave : hazard controller side
interface pipeline_ctrl_if #(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned NUMSRC       = 2,
  parameter int unsigned CNTWIDTH     = 16
);
  logic [NUMSRC*ADDRESSWIDTH-1:0] srcAddrD;
  logic [NUMSRC-1:0]              srcValidD;
  logic [NUMSRC*ADDRESSWIDTH-1:0] srcAddrE;
  logic [NUMSRC-1:0]              srcValidE;
  logic [ADDRESSWIDTH-1:0]        destAddrE;
  logic                           writeEnableE;
  logic                           isLoadE;
  logic                           isMultiE;
  logic [ADDRESSWIDTH-1:0]        destAddrM;
  logic                           writeEnableM;
  logic [ADDRESSWIDTH-1:0]        destAddrWB;
  logic                           writeEnableWB;
  logic                           takeBranchE;
  logic [2*NUMSRC-1:0]            forwardSelE;
  logic                           stallF;
  logic                           stallD;
  logic                           stallE;
  logic                           flushD;
  logic                           flushE;
  logic                           bubbleM;
  logic [CNTWIDTH-1:0]            stallCycles;
  logic [CNTWIDTH-1:0]            flushCount;

  modport master (
    output srcAddrD, srcValidD, srcAddrE, srcValidE, destAddrE, writeEnableE,
           isLoadE, isMultiE, destAddrM, writeEnableM, destAddrWB,
           writeEnableWB, takeBranchE,
    input  forwardSelE, stallF, stallD, stallE, flushD, flushE, bubbleM,
           stallCycles, flushCount
  );

  modport slave (
    input  srcAddrD, srcValidD, srcAddrE, srcValidE, destAddrE, writeEnableE,
           isLoadE, isMultiE, destAddrM, writeEnableM, destAddrWB,
           writeEnableWB, takeBranchE,
    output forwardSelE, stallF, stallD, stallE, flushD, flushE, bubbleM,
           stallCycles, flushCount
  );
endinterface

// File: rtl/fwd_select.sv
// Forward select for one Execute-stage source operand.
// Ports: src_addr_i/src_valid_i operand, dest_m_i/we_m_i Memory-stage
// writer, dest_wb_i/we_wb_i Writeback-stage writer, sel_o select (comb).
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = 4
) (
  input  logic [ADDRESSWIDTH-1:0] src_addr_i,
  input  logic                    src_valid_i,
  input  logic [ADDRESSWIDTH-1:0] dest_m_i,
  input  logic                    we_m_i,
  input  logic [ADDRESSWIDTH-1:0] dest_wb_i,
  input  logic                    we_wb_i,
  output fwd_sel_t                sel_o
);

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    sel_o = FWD_REG;
    if (src_valid_i && we_m_i && (src_addr_i == dest_m_i)) begin
      sel_o = FWD_M;
    end else if (src_valid_i && we_wb_i && (src_addr_i == dest_wb_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// flush, multi-cycle execute hold and saturating performance counters.
// Ports: clock, reset (sync active-low), bus (pipeline_ctrl_if.slave).
// Forward/stall/flush controls are combinational; counters are registered.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned ADDRESSWIDTH = 4,
  parameter int unsigned NUMSRC       = 2,
  parameter int unsigned MCLATENCY    = 4,
  parameter int unsigned CNTWIDTH     = 16
) (
  input logic            clock,
  input logic            reset,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned AW      = ADDRESSWIDTH;
  localparam int unsigned CW      = (MCLATENCY < 4) ? 1 : $clog2(MCLATENCY);
  localparam int unsigned MC_LOAD = (MCLATENCY >= 3) ? (MCLATENCY - 2) : 0;

  pipe_state_t         state_q, state_d, state_c;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                src_match_c;
  logic                lu_hazard_c;
  logic                mc_entry_c;
  logic                hold_c;
  logic                stall_f_c, stall_d_c, stall_e_c;
  logic                flush_d_c, flush_e_c, bubble_m_c;
  logic [CNTWIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNTWIDTH-1:0] flush_count_q, flush_count_d;
  fwd_sel_t            fwd_sel_c [NUMSRC];
  logic [2*NUMSRC-1:0] fwd_pack_c;

  // One forward selector per Execute-stage source.
  for (genvar g = 0; g < NUMSRC; g++) begin : g_fwd
    fwd_select #(.ADDRESSWIDTH(AW)) u_fwd (
      .src_addr_i (bus.srcAddrE[g*AW +: AW]),
      .src_valid_i(bus.srcValidE[g]),
      .dest_m_i   (bus.destAddrM),
      .we_m_i     (bus.writeEnableM),
      .dest_wb_i  (bus.destAddrWB),
      .we_wb_i    (bus.writeEnableWB),
      .sel_o      (fwd_sel_c[g])
    );
  end

  always_comb begin
    fwd_pack_c = '0;
    for (int i = 0; i < NUMSRC; i++) begin
      fwd_pack_c[2*i +: 2] = fwd_sel_c[i];
    end
  end

  // Controls see RUN while reset is held so they stay meaningful in reset.
  assign state_c = reset ? state_q : ST_RUN;

  // Any valid Decode source reading the Execute-stage destination.
  always_comb begin
    src_match_c = 1'b0;
    for (int i = 0; i < NUMSRC; i++) begin
      if (bus.srcValidD[i] && (bus.srcAddrD[i*AW +: AW] == bus.destAddrE)) begin
        src_match_c = 1'b1;
      end
    end
  end

  assign lu_hazard_c = (state_c == ST_RUN) && bus.isLoadE && bus.writeEnableE &&
                       src_match_c && !bus.takeBranchE;
  assign mc_entry_c  = (state_c == ST_RUN) && bus.isMultiE && !bus.takeBranchE &&
                       (MCLATENCY >= 2);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state; the counter tracks remaining MCBUSY cycles.
  always_comb begin
    state_d = state_c;
    cnt_d   = cnt_q;
    unique case (state_c)
      ST_RUN: begin
        if (mc_entry_c) begin
          if (MCLATENCY >= 3) begin
            state_d = ST_MCBUSY;
            cnt_d   = CW'(MC_LOAD);
          end else begin
            state_d = ST_MCDONE;
          end
        end
      end
      ST_MCBUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_MCDONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_MCDONE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // FSM outputs: hold the front end while the multi-cycle op occupies E.
  always_comb begin
    hold_c     = mc_entry_c || (state_c == ST_MCBUSY);
    stall_f_c  = hold_c || lu_hazard_c;
    stall_d_c  = hold_c || lu_hazard_c;
    stall_e_c  = hold_c;
    bubble_m_c = hold_c;
    flush_d_c  = bus.takeBranchE;
    flush_e_c  = bus.takeBranchE || lu_hazard_c;
  end

  // Saturating performance counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_f_c && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNTWIDTH'(1);
    end
    if (bus.takeBranchE && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNTWIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.forwardSelE = fwd_pack_c;
  assign bus.stallF      = stall_f_c;
  assign bus.stallD      = stall_d_c;
  assign bus.stallE      = stall_e_c;
  assign bus.flushD      = flush_d_c;
  assign bus.flushE      = flush_e_c;
  assign bus.bubbleM     = bubble_m_c;
  assign bus.stallCycles = stall_cycles_q;
  assign bus.flushCount  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver computes expected outputs
// from a cycle-level model of the pipeline rules; the monitor compares.
module tb_pipeline_ctrl;
  localparam int AW   = 4;
  localparam int NS   = 2;
  localparam int ML   = 4;
  localparam int CWID = 4;
  localparam int CMAX = (1 << CWID) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.ADDRESSWIDTH(AW), .NUMSRC(NS), .CNTWIDTH(CWID)) bus ();

  pipeline_ctrl #(
    .ADDRESSWIDTH(AW), .NUMSRC(NS), .MCLATENCY(ML), .CNTWIDTH(CWID)
  ) u_dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [2*NS-1:0] fwd;
    logic            sF, sD, sE, fD, fE, bM;
    logic [CWID-1:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  // Model: cycles the multi-cycle op still occupies E (0 = free), counters.
  int mc_left = 0;
  int m_sc = 0;
  int m_fc = 0;

  task automatic clear_inputs();
    bus.srcAddrD = '0; bus.srcValidD = '0;
    bus.srcAddrE = '0; bus.srcValidE = '0;
    bus.destAddrE = '0; bus.writeEnableE = 1'b0;
    bus.isLoadE = 1'b0; bus.isMultiE = 1'b0;
    bus.destAddrM = '0; bus.writeEnableM = 1'b0;
    bus.destAddrWB = '0; bus.writeEnableWB = 1'b0;
    bus.takeBranchE = 1'b0;
  endtask

  // Predict this cycle's outputs, queue them, advance the model one edge.
  task automatic cycle();
    exp_t e;
    int   left, sel;
    bit   hit, lu, entry, hold;
    logic [AW-1:0] a;
    left = rst_n ? mc_left : 0;
    for (int i = 0; i < NS; i++) begin
      a = bus.srcAddrE[i*AW +: AW];
      sel = 0;
      if (bus.srcValidE[i] && bus.writeEnableM && a == bus.destAddrM) sel = 2;
      else if (bus.srcValidE[i] && bus.writeEnableWB && a == bus.destAddrWB) sel = 1;
      e.fwd[2*i +: 2] = 2'(sel);
    end
    hit = 1'b0;
    for (int i = 0; i < NS; i++) begin
      a = bus.srcAddrD[i*AW +: AW];
      if (bus.srcValidD[i] && a == bus.destAddrE) hit = 1'b1;
    end
    lu    = (left == 0) && bus.isLoadE && bus.writeEnableE && hit && !bus.takeBranchE;
    entry = (left == 0) && bus.isMultiE && !bus.takeBranchE && (ML >= 2);
    hold  = entry || (left > 1);
    e.sF = hold || lu; e.sD = hold || lu; e.sE = hold; e.bM = hold;
    e.fD = bus.takeBranchE; e.fE = bus.takeBranchE || lu;
    e.sc = CWID'(m_sc); e.fc = CWID'(m_fc);
    q.push_back(e);
    if (!rst_n) begin
      mc_left = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (entry) mc_left = ML - 1;
      else if (left > 0) mc_left = left - 1;
      if (e.sF && m_sc < CMAX) m_sc++;
      if (bus.takeBranchE && m_fc < CMAX) m_fc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // Forwarding priority: M over WB, then WB, then register file.
    bus.destAddrWB = 4'd3; bus.writeEnableWB = 1'b1;
    bus.destAddrM = 4'd3; bus.writeEnableM = 1'b1;
    bus.srcAddrE = {4'd7, 4'd3}; bus.srcValidE = 2'b01;
    cycle();
    bus.writeEnableM = 1'b0; cycle();
    bus.writeEnableWB = 1'b0; cycle();
    clear_inputs();

    // Load-use on operand 1, single cycle.
    bus.isLoadE = 1'b1; bus.writeEnableE = 1'b1; bus.destAddrE = 4'd5;
    bus.srcAddrD = {4'd5, 4'd2}; bus.srcValidD = 2'b10;
    cycle();
    clear_inputs(); cycle();

    // Multi-cycle op with isMultiE held high throughout.
    bus.isMultiE = 1'b1;
    repeat (6) cycle();
    clear_inputs(); cycle();

    // Branch beats multi-cycle entry and load-use in the same cycle.
    bus.isMultiE = 1'b1; bus.takeBranchE = 1'b1;
    bus.isLoadE = 1'b1; bus.writeEnableE = 1'b1; bus.destAddrE = 4'd9;
    bus.srcAddrD = {4'd1, 4'd9}; bus.srcValidD = 2'b01;
    cycle();
    clear_inputs(); cycle(); cycle();

    // Reset during the second MCBUSY cycle abandons the op.
    bus.isMultiE = 1'b1; cycle();
    bus.isMultiE = 1'b0; cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; cycle(); cycle();

    // Stall counter saturation.
    bus.isLoadE = 1'b1; bus.writeEnableE = 1'b1; bus.destAddrE = 4'd4;
    bus.srcAddrD = {4'd4, 4'd4}; bus.srcValidD = 2'b11;
    repeat ((1 << CWID) + 5) cycle();
    clear_inputs(); cycle();

    // Randomized traffic over a small register window to provoke matches.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      for (int i = 0; i < NS; i++) begin
        bus.srcAddrD[i*AW +: AW] = AW'($urandom_range(0, 3));
        bus.srcAddrE[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      bus.srcValidD = NS'($urandom);
      bus.srcValidE = NS'($urandom);
      bus.destAddrE = AW'($urandom_range(0, 3));
      bus.destAddrM = AW'($urandom_range(0, 3));
      bus.destAddrWB = AW'($urandom_range(0, 3));
      bus.writeEnableE = 1'($urandom);
      bus.writeEnableM = 1'($urandom);
      bus.writeEnableWB = 1'($urandom);
      bus.isLoadE = 1'($urandom);
      bus.isMultiE = ($urandom_range(0, 5) == 0);
      bus.takeBranchE = (mc_left == 0 || !rst_n) ? ($urandom_range(0, 7) == 0) : 1'b0;
      cycle();
    end
    stim_done = 1'b1;
  end

  // Monitor: pop one expectation per cycle and compare every output.
  initial begin
    exp_t e;
    int idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        idle = 0;
        e = q.pop_front();
        chk("forwardSelE", 32'(bus.forwardSelE), 32'(e.fwd));
        chk("stallF", 32'(bus.stallF), 32'(e.sF));
        chk("stallD", 32'(bus.stallD), 32'(e.sD));
        chk("stallE", 32'(bus.stallE), 32'(e.sE));
        chk("flushD", 32'(bus.flushD), 32'(e.fD));
        chk("flushE", 32'(bus.flushE), 32'(e.fE));
        chk("bubbleM", 32'(bus.bubbleM), 32'(e.bM));
        chk("stallCycles", 32'(bus.stallCycles), 32'(e.sc));
        chk("flushCount", 32'(bus.flushCount), 32'(e.fc));
      end else if (stim_done) begin
        break;
      end else begin
        idle++;
        if (idle > 100) begin
          errors++;
          $display("FAIL timeout got=idle exp=stimulus at %0t", $time);
          break;
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
